div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one serial divider datapath between NREQ independent requesters.
- Performs round-robin grant, latches the winning operands and pulses the divider start.
- Waits for divider completion, with a watchdog, and returns quotient, remainder and requester ID over a valid/ready response channel.
- Sits between the Wishbone/LA-facing requester logic and the bare divider core inside the wrapped project.

Parameters:
- NREQ, 4: number of requesters; 2..8.
- XLEN, 32: data width of dividend, divisor, quotient and remainder.
- TIMEOUT, 2*XLEN+8: maximum cycles spent in WAIT before an error response.
- IDW, $clog2(NREQ): width of the requester ID (derived; not overridden).

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NREQ  per-requester operand valid.
- req_ready_o  out  NREQ  one-hot grant/accept; only in IDLE.
- req_dividend_i  in  NREQ*XLEN  flattened; slice k = requester k.
- req_divisor_i  in  NREQ*XLEN  flattened; slice k = requester k.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_id_o  out  IDW  requester that owns the response.
- rsp_quotient_o  out  XLEN  quotient.
- rsp_remainder_o  out  XLEN  remainder.
- rsp_err_o  out  1  watchdog timeout on this response.
- div_start_o  out  1  one-cycle start pulse to divider.
- div_dividend_o  out  XLEN  latched dividend, stable from start until done.
- div_divisor_o  out  XLEN  latched divisor.
- div_done_i  in  1  divider completion pulse.
- div_quotient_i  in  XLEN  valid when div_done_i=1.
- div_remainder_i  in  XLEN  valid when div_done_i=1.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high on reset_i. Reset takes effect at the next clk_i edge.
- Reset values: all outputs 0; state=IDLE; last_grant=NREQ-1, so requester 0 wins first; watchdog count=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, entry:
  - If any req_valid_i: grant = first set bit searching from last_grant+1 modulo NREQ.
  - req_ready_o[grant]=1 combinationally, that cycle only; handshake = valid & ready.
  - Operands and grant ID are latched; next state ISSUE.
  - If no req_valid_i: stay in IDLE; req_ready_o=0.
- ISSUE: div_start_o=1 for exactly one cycle; watchdog cleared; next state WAIT.
- WAIT:
  - On div_done_i: latch quotient and remainder, rsp_err_o=0, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without done: quotient=0, remainder=0, rsp_err_o=1, go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid_o=1 with all rsp_* fields held stable until rsp_ready_i=1.
  - On handshake: last_grant=grant, rsp_valid_o=0 next cycle, go to IDLE.
- Latency: accept at cycle 0, div_start_o at cycle 1, done at 1+D, rsp_valid_o at 2+D. Minimum request-to-request gap is D+3 cycles.
- div_done_i outside WAIT is ignored, including a late done after a timeout.
- Only one operation is outstanding. req_ready_o is all-zero in ISSUE, WAIT and RESP.
- A requester may drop req_valid_i before it is granted; no state is kept for it.
- Fairness: a requester that holds valid is served within NREQ grants.
- Reset mid-operation: the operation is abandoned with no response. The divider shares reset_i. First grant after reset goes to requester 0 if it is valid.
- Widths: the arbiter does no arithmetic on data. The watchdog counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Optional Feature:
- Macro: DIV_ARB_DIVZERO_BYPASS_EN.
- Defined:
  - A granted request with divisor==0 skips ISSUE and WAIT and goes from IDLE straight to RESP.
  - Response: quotient={XLEN{1'b1}}, remainder=dividend, rsp_err_o=0, rsp_valid_o asserted 1 cycle after acceptance.
  - No div_start_o pulse.
- Undefined: zero divisors go to the divider like any other operand; its result is passed through unchanged.

Decomposition:
- Package div_arb_pkg: FSM state enum (IDLE, ISSUE, WAIT, RESP); localparams for the default TIMEOUT formula and the divide-by-zero quotient constant; function clog2_min1 for IDW when NREQ=1.
- Sub-module rr_arbiter (NREQ): purely combinational. Inputs: request vector, last_grant. Outputs: one-hot grant, encoded ID, any_req.
- The FSM, operand/result registers and watchdog stay in div_arbiter.

Test Plan:
- Single request: req0 dividend=100, divisor=7, model D=34 → exactly one div_start_o; rsp_valid_o at cycle 36; id=0, q=14, r=2, err=0.
- All 4 requesters valid after reset, each holding until accepted → grant order 0,1,2,3. Reassert all → next grant 0. req_ready_o never has more than one bit set.
- rsp_ready_i held low 10 cycles in RESP → rsp_valid_o stays high, data stable, req_ready_o stays 0, no new div_start_o.
- Divider model never asserts done, TIMEOUT=72 → rsp_err_o=1 with q=0, r=0 exactly 72 cycles after div_start_o. A late done_i is then ignored.
- divisor=0, dividend=0x1234 → with macro: rsp q=0xFFFFFFFF, r=0x1234 one cycle after accept, no start pulse. Without macro: start pulse issued and divider result passed through.
- reset_i high for 1 cycle during WAIT → next cycle all outputs 0 and busy_o=0; no response for the lost operation; next grant goes to requester 0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter slice.
package div_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // Default watchdog: serial divider worst case plus a little slack.
  localparam int TIMEOUT_XLEN_MULT = 2;
  localparam int TIMEOUT_SLACK     = 8;

  localparam logic [63:0] DIVZERO_Q = {64{1'b1}};

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant_i wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_req_o
);

  logic [IDW:0]      sh;
  logic [NREQ-1:0]   rot, rot_first;
  logic [IDW-1:0]    id_chain [NREQ+1];

  // Rotate so bit 0 is the requester right after last_grant, isolate the
  // lowest set bit, then rotate back.
  assign sh        = {1'b0, last_grant_i} + 1'b1;
  assign rot       = NREQ'({req_i, req_i} >> sh);
  assign rot_first = rot & (~rot + 1'b1);
  assign gnt_o     = NREQ'(({rot_first, rot_first} << sh) >> NREQ);
  assign any_req_o = |req_i;

  assign id_chain[0] = '0;
  for (genvar j = 0; j < NREQ; j++) begin : g_enc
    assign id_chain[j+1] = id_chain[j] | (gnt_o[j] ? IDW'(j) : '0);
  end
  assign gnt_id_o = id_chain[NREQ];

endmodule

// File: rtl/div_arbiter.sv
// Shares one serial divider among NREQ requesters with a watchdog on WAIT.
// Optional DIV_ARB_DIVZERO_BYPASS_EN answers divisor==0 without the divider.
module div_arbiter import div_arb_pkg::*; #(
  parameter  int NREQ    = 4,
  parameter  int XLEN    = 32,
  parameter  int TIMEOUT = TIMEOUT_XLEN_MULT*XLEN + TIMEOUT_SLACK,
  localparam int IDW     = clog2_min1(NREQ)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*XLEN-1:0] req_dividend_i,
  input  logic [NREQ*XLEN-1:0] req_divisor_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [XLEN-1:0]      rsp_quotient_o,
  output logic [XLEN-1:0]      rsp_remainder_o,
  output logic                 rsp_err_o,
  output logic                 div_start_o,
  output logic [XLEN-1:0]      div_dividend_o,
  output logic [XLEN-1:0]      div_divisor_o,
  input  logic                 div_done_i,
  input  logic [XLEN-1:0]      div_quotient_i,
  input  logic [XLEN-1:0]      div_remainder_i,
  output logic                 busy_o
);

  localparam int WDW = $clog2(TIMEOUT+1);

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d, id_q, id_d;
  logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic            err_q, err_d;
  logic [WDW-1:0]  wd_q, wd_d, wd_inc;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            any_req;
  logic [XLEN-1:0] dvd_chain [NREQ+1];
  logic [XLEN-1:0] dvs_chain [NREQ+1];

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i       (req_valid_i),
    .last_grant_i(last_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .any_req_o   (any_req)
  );

  // One-hot AND-OR operand select keyed by the grant.
  assign dvd_chain[0] = '0;
  assign dvs_chain[0] = '0;
  for (genvar k = 0; k < NREQ; k++) begin : g_sel
    assign dvd_chain[k+1] = dvd_chain[k] | ({XLEN{gnt[k]}} & req_dividend_i[k*XLEN +: XLEN]);
    assign dvs_chain[k+1] = dvs_chain[k] | ({XLEN{gnt[k]}} & req_divisor_i[k*XLEN +: XLEN]);
  end

  assign wd_inc = (wd_q == WDW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    err_d       = err_q;
    wd_d        = wd_q;
    req_ready_o = '0;
    div_start_o = 1'b0;
    unique case (state_q)
      IDLE: if (any_req) begin
        req_ready_o = gnt;
        id_d        = gnt_id;
        dvd_d       = dvd_chain[NREQ];
        dvs_d       = dvs_chain[NREQ];
        state_d     = ISSUE;
`ifdef DIV_ARB_DIVZERO_BYPASS_EN
        if (dvs_chain[NREQ] == '0) begin
          quo_d   = DIVZERO_Q[XLEN-1:0];
          rem_d   = dvd_chain[NREQ];
          err_d   = 1'b0;
          state_d = RESP;
        end
`endif
      end
      ISSUE: begin
        div_start_o = 1'b1;
        wd_d        = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        wd_d = wd_inc;
        if (div_done_i) begin
          quo_d   = div_quotient_i;
          rem_d   = div_remainder_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_inc >= WDW'(TIMEOUT-1)) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready_i) begin
        last_d  = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ-1);
      id_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign rsp_valid_o     = (state_q == RESP);
  assign busy_o          = (state_q != IDLE);
  assign rsp_id_o        = id_q;
  assign rsp_quotient_o  = quo_q;
  assign rsp_remainder_o = rem_q;
  assign rsp_err_o       = err_q;
  assign div_dividend_o  = dvd_q;
  assign div_divisor_o   = dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, acceptance scoreboard, scenario tasks.
`timescale 1ns/1ps
module tb_div_arbiter;
  localparam int NREQ = 4, XLEN = 32, TMO = 2*XLEN + 8;

  typedef struct {
    logic [1:0]      id;
    logic [XLEN-1:0] q, r;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i, rsp_ready, late_done;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [XLEN-1:0]      dvd [NREQ];
  logic [XLEN-1:0]      dvs [NREQ];
  logic [NREQ*XLEN-1:0] req_dividend, req_divisor;
  logic                 rsp_valid, rsp_err, div_start, div_done, busy;
  logic [1:0]           rsp_id;
  logic [XLEN-1:0]      rsp_q, rsp_r, div_dividend, div_divisor, div_q, div_r;

  always_comb begin
    req_dividend = '0;
    req_divisor  = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_dividend[k*XLEN +: XLEN] = dvd[k];
      req_divisor[k*XLEN +: XLEN]  = dvs[k];
    end
  end

  div_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_quotient_o(rsp_q), .rsp_remainder_o(rsp_r), .rsp_err_o(rsp_err),
    .div_start_o(div_start), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_done_i(div_done), .div_quotient_i(div_q), .div_remainder_i(div_r),
    .busy_o(busy)
  );

  // Divider model: done high D cycles after the start cycle, never if hung.
  int              div_lat = 34;
  bit              div_hang = 0;
  logic            m_done, m_busy;
  int              m_cnt;
  logic [XLEN-1:0] m_a, m_b, m_q, m_r;
  always @(posedge clk) begin
    if (reset_i) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (div_start) begin
        m_busy <= 1'b1; m_cnt <= 1; m_a <= div_dividend; m_b <= div_divisor;
      end else if (m_busy && !div_hang) begin
        if (m_cnt >= div_lat - 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_q <= (m_b == 0) ? '1 : m_a / m_b;
          m_r <= (m_b == 0) ? m_a : m_a % m_b;
        end else m_cnt <= m_cnt + 1;
      end
    end
  end
  assign div_done = m_done | late_done;
  assign div_q    = late_done ? 32'hDEAD_BEEF : m_q;
  assign div_r    = late_done ? 32'hFEED_F00D : m_r;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0, n_err = 0;
  int   acc_log[$];
  int   acc_cyc = 0, start_cnt = 0, start_cyc = 0, rsp_cnt = 0, rsp_rise_cyc = 0, onehot_viol = 0;
  bit   prev_rv = 1'b0;
  exp_t sb[$];

  // Push on accept, pop and compare on response handshake.
  always @(posedge clk) begin
    int   id;
    exp_t e;
    if (reset_i) prev_rv = 1'b0;
    else begin
      if ($countones(req_ready) > 1) onehot_viol++;
      if (div_start) begin start_cnt++; start_cyc = cyc; end
      if (|(req_valid & req_ready)) begin
        id = 0;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) id = k;
        acc_log.push_back(id);
        acc_cyc = cyc;
        e.id = 2'(id);
        if (div_hang)         begin e.q = '0; e.r = '0; e.err = 1'b1; end
        else if (dvs[id] == 0) begin e.q = '1; e.r = dvd[id]; e.err = 1'b0; end
        else begin e.q = dvd[id] / dvs[id]; e.r = dvd[id] % dvs[id]; e.err = 1'b0; end
        sb.push_back(e);
      end
      if (rsp_valid && !prev_rv) rsp_rise_cyc = cyc;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_rsp got id=%0d q=%h r=%h err=%b want no response", rsp_id, rsp_q, rsp_r, rsp_err);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_q, rsp_r, rsp_err} !== {e.id, e.q, e.r, e.err}) begin
            n_err++;
            $display("FAIL sb_rsp got id=%0d q=%h r=%h err=%b want id=%0d q=%h r=%h err=%b",
                     rsp_id, rsp_q, rsp_r, rsp_err, e.id, e.q, e.r, e.err);
          end
        end
        rsp_cnt++;
      end
    end
  end

  // Drive on the falling edge; requesters drop valid once accepted.
  int acc_seen = 0;
  task automatic tick();
    @(negedge clk);
    while (acc_seen < acc_log.size()) begin
      req_valid[acc_log[acc_seen]] = 1'b0;
      acc_seen++;
    end
  endtask

  task automatic do_reset();
    req_valid = '0; rsp_ready = 1'b1; div_hang = 0; late_done = 1'b0;
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({rsp_valid, rsp_err, div_start, busy} !== 4'b0) begin n_err++;
      $display("FAIL reset_ctrl got %b want 0000", {rsp_valid, rsp_err, div_start, busy}); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready got %b want 0", req_ready); end
    n_cmp++; if ({div_dividend, div_divisor} !== '0) begin n_err++;
      $display("FAIL reset_div_ops got %h/%h want 0", div_dividend, div_divisor); end
    n_cmp++; if ({rsp_q, rsp_r, rsp_id} !== '0) begin n_err++;
      $display("FAIL reset_rsp got q=%h r=%h id=%0d want 0", rsp_q, rsp_r, rsp_id); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_req busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int s0, b, k;
    do_reset();
    div_lat = 34; dvd[0] = 100; dvs[0] = 7;
    s0 = start_cnt; b = rsp_cnt;
    req_valid = 4'b0001;
    k = 0; while (rsp_cnt == b && k < 200) begin tick(); k++; end
    n_cmp++; if (rsp_cnt !== b + 1) begin n_err++; $display("FAIL single_rsp got %0d rsps want %0d", rsp_cnt - b, 1); end
    n_cmp++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL single_starts got %0d want 1", start_cnt - s0); end
    n_cmp++; if (start_cyc - acc_cyc !== 1) begin n_err++; $display("FAIL single_start_lat got %0d want 1", start_cyc - acc_cyc); end
    n_cmp++; if (rsp_rise_cyc - acc_cyc !== 36) begin n_err++; $display("FAIL single_rsp_lat got %0d want 36", rsp_rise_cyc - acc_cyc); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int base, b, k;
    do_reset();
    div_lat = 5;
    for (int i = 0; i < NREQ; i++) begin dvd[i] = 1000 + i*37; dvs[i] = i + 3; end
    base = acc_log.size(); b = rsp_cnt;
    req_valid = 4'hF;
    k = 0; while (rsp_cnt - b < 4 && k < 400) begin tick(); k++; end
    req_valid = 4'hF;
    k = 0; while (rsp_cnt - b < 8 && k < 400) begin tick(); k++; end
    n_cmp++; if (rsp_cnt - b !== 8) begin n_err++; $display("FAIL rr_rsp_count got %0d want 8", rsp_cnt - b); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (acc_log.size() <= base + i || acc_log[base + i] !== i % 4) begin n_err++;
        $display("FAIL rr_order slot %0d got %0d want %0d", i, (acc_log.size() > base + i) ? acc_log[base + i] : -1, i % 4); end
    end
    n_cmp++; if (onehot_viol !== 0) begin n_err++; $display("FAIL rr_onehot got %0d violations want 0", onehot_viol); end
  endtask

  task automatic test_resp_stall();
    int s0, b, k, bad;
    do_reset();
    div_lat = 8; dvd[2] = 1000; dvs[2] = 9; dvd[0] = 77; dvs[0] = 7;
    rsp_ready = 1'b0; b = rsp_cnt;
    req_valid = 4'b0100;
    k = 0; while (!rsp_valid && k < 100) begin tick(); k++; end
    req_valid[0] = 1'b1;
    s0 = start_cnt; bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(rsp_valid === 1'b1 && rsp_q === 111 && rsp_r === 1 && rsp_id === 2 && req_ready === '0)) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    n_cmp++; if (start_cnt !== s0) begin n_err++; $display("FAIL stall_start got %0d starts want 0", start_cnt - s0); end
    rsp_ready = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got %b want 0", rsp_valid); end
    k = 0; while (rsp_cnt - b < 2 && k < 100) begin tick(); k++; end
    n_cmp++; if (rsp_cnt - b !== 2 || acc_log[acc_log.size()-1] !== 0) begin n_err++;
      $display("FAIL stall_next got rsps=%0d last=%0d want rsps=2 last=0", rsp_cnt - b, acc_log[acc_log.size()-1]); end
  endtask

  task automatic test_timeout();
    int s0, b, k;
    do_reset();
    div_hang = 1; rsp_ready = 1'b0; dvd[1] = 50; dvs[1] = 5;
    b = rsp_cnt;
    req_valid = 4'b0010;
    k = 0; while (!rsp_valid && k < 200) begin tick(); k++; end
    tick();
    n_cmp++; if (rsp_rise_cyc - start_cyc !== TMO) begin n_err++;
      $display("FAIL timeout_lat got %0d want %0d", rsp_rise_cyc - start_cyc, TMO); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_q, rsp_r} !== {1'b1, 1'b1, 64'h0}) begin n_err++;
      $display("FAIL timeout_rsp got v=%b err=%b q=%h r=%h want 1 1 0 0", rsp_valid, rsp_err, rsp_q, rsp_r); end
    late_done = 1'b1; tick(); late_done = 1'b0; tick();
    n_cmp++; if ({rsp_valid, rsp_err, rsp_q, rsp_r} !== {1'b1, 1'b1, 64'h0}) begin n_err++;
      $display("FAIL late_done_resp got v=%b err=%b q=%h r=%h want 1 1 0 0", rsp_valid, rsp_err, rsp_q, rsp_r); end
    rsp_ready = 1'b1; tick();
    s0 = start_cnt;
    late_done = 1'b1; tick(); late_done = 1'b0; tick();
    n_cmp++; if ({busy, rsp_valid} !== 2'b00 || start_cnt !== s0 || rsp_cnt - b !== 1) begin n_err++;
      $display("FAIL late_done_idle got busy=%b v=%b rsps=%0d want 0 0 1", busy, rsp_valid, rsp_cnt - b); end
    div_hang = 0;
  endtask

  task automatic test_divzero();
    int s0, b, k;
    do_reset();
    div_lat = 6; dvd[3] = 32'h1234; dvs[3] = 0;
    s0 = start_cnt; b = rsp_cnt;
    req_valid = 4'b1000;
    k = 0; while (rsp_cnt == b && k < 100) begin tick(); k++; end
    n_cmp++; if (rsp_cnt !== b + 1) begin n_err++; $display("FAIL divzero_rsp got %0d want 1", rsp_cnt - b); end
`ifdef DIV_ARB_DIVZERO_BYPASS_EN
    n_cmp++; if (start_cnt - s0 !== 0) begin n_err++; $display("FAIL divzero_start got %0d want 0", start_cnt - s0); end
    n_cmp++; if (rsp_rise_cyc - acc_cyc !== 1) begin n_err++; $display("FAIL divzero_lat got %0d want 1", rsp_rise_cyc - acc_cyc); end
`else
    n_cmp++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL divzero_start got %0d want 1", start_cnt - s0); end
    n_cmp++; if (rsp_rise_cyc - acc_cyc !== 8) begin n_err++; $display("FAIL divzero_lat got %0d want 8", rsp_rise_cyc - acc_cyc); end
`endif
  endtask

  task automatic test_reset_mid();
    int s0, b, base, k;
    do_reset();
    div_lat = 30; dvd[2] = 500; dvs[2] = 3;
    s0 = start_cnt; b = rsp_cnt;
    req_valid = 4'b0100;
    k = 0; while (start_cnt == s0 && k < 20) begin tick(); k++; end
    tick(); tick(); tick();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    sb.delete();
    n_cmp++; if ({busy, rsp_valid, rsp_err, div_start, req_ready} !== '0) begin n_err++;
      $display("FAIL midrst_ctrl got busy=%b v=%b err=%b st=%b rdy=%b want 0", busy, rsp_valid, rsp_err, div_start, req_ready); end
    n_cmp++; if ({div_dividend, div_divisor, rsp_q, rsp_r, rsp_id} !== '0) begin n_err++;
      $display("FAIL midrst_data got dvd=%h dvs=%h q=%h r=%h id=%0d want 0", div_dividend, div_divisor, rsp_q, rsp_r, rsp_id); end
    for (int i = 0; i < 40; i++) tick();
    n_cmp++; if (rsp_cnt !== b) begin n_err++; $display("FAIL midrst_lost got %0d rsps want 0", rsp_cnt - b); end
    dvd[0] = 9; dvs[0] = 2; div_lat = 4;
    base = acc_log.size();
    req_valid = 4'b0101;
    k = 0; while (rsp_cnt - b < 2 && k < 200) begin tick(); k++; end
    n_cmp++; if (acc_log.size() <= base || acc_log[base] !== 0) begin n_err++;
      $display("FAIL midrst_first_grant got %0d want 0", (acc_log.size() > base) ? acc_log[base] : -1); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish before 2ms");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_i = 1'b1; req_valid = '0; rsp_ready = 1'b1; late_done = 1'b0;
    for (int k = 0; k < NREQ; k++) begin dvd[k] = '0; dvs[k] = 32'd1; end
    test_reset();
    test_single();
    test_round_robin();
    test_resp_stall();
    test_timeout();
    test_divzero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
